// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared race state encoding, key codes and time limits
package race_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_COUNTDOWN = 3'b001,
    ST_RACE      = 3'b010,
    ST_PAUSE     = 3'b011,
    ST_FINISH    = 3'b100
  } race_state_e;

  // One-hot key levels, shared with the menu FSM
  localparam logic [5:0] KEY_NONE  = 6'b000000;
  localparam logic [5:0] KEY_UP    = 6'b000001;
  localparam logic [5:0] KEY_DOWN  = 6'b000010;
  localparam logic [5:0] KEY_LEFT  = 6'b000100;
  localparam logic [5:0] KEY_RIGHT = 6'b001000;
  localparam logic [5:0] KEY_ENTER = 6'b010000;
  localparam logic [5:0] KEY_ESC   = 6'b100000;

  localparam logic [15:0] LAP_MAX_CS   = 16'd59999;
  localparam logic [15:0] BEST_NONE    = 16'hFFFF;
  localparam logic [17:0] TOTAL_MAX_CS = 18'h3FFFF;

endpackage

// File: rtl/cs_tick.sv
// rtl/cs_tick.sv - centisecond prescaler, one tick per CLK_TICKS cycles while running
module cs_tick #(
  parameter int CLK_TICKS = 650_000
) (
  input  logic pclk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLK_TICKS > 1) ? $clog2(CLK_TICKS) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == TERM);

  // Held at zero while stopped, so a pause drops the partial centisecond
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || !run || tick) cnt_d = '0;
  end

  always_ff @(posedge pclk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/race_ctrl.sv
// rtl/race_ctrl.sv - race sequencer: countdown, lap timing/validation, pause and finish
module race_ctrl
  import race_pkg::*;
#(
  parameter int CLK_TICKS   = 650_000,
  parameter int LAPS        = 3,
  parameter int COUNTDOWN_S = 3
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [5:0]  key_i,
  input  logic        checkpoint_hit_i,
  input  logic        finish_line_hit_i,
  output logic [2:0]  race_state_o,
  output logic [1:0]  countdown_val_o,
  output logic        player_enable_o,
  output logic        go_pulse_o,
  output logic [2:0]  lap_count_o,
  output logic [15:0] lap_time_cs_o,
  output logic [15:0] best_lap_cs_o,
  output logic [17:0] total_time_cs_o,
  output logic        race_done_o
);

  localparam logic [1:0] CD_INIT   = 2'(COUNTDOWN_S);
  localparam logic [2:0] LAPS_DONE = 3'(LAPS);
  localparam logic [6:0] SEC_LAST  = 7'd99;

  race_state_e state_q, state_d;
  logic        start_q;
  logic [5:0]  key_q;
  logic        armed_q, armed_d;
  logic [1:0]  cd_q, cd_d;
  logic [6:0]  sec_q, sec_d;
  logic        pen_q, pen_d;
  logic        go_q, go_d;
  logic [2:0]  laps_q, laps_d;
  logic [15:0] lap_t_q, lap_t_d;
  logic [15:0] best_q, best_d;
  logic [17:0] total_q, total_d;
  logic        done_q, done_d;
  logic        lap_ev;

  logic key_ev, esc_ev, enter_ev;
  logic tick, tick_run, tick_clear;

  assign key_ev   = (key_i != KEY_NONE) && (key_q == KEY_NONE);
  assign esc_ev   = key_ev && (key_i == KEY_ESC);
  assign enter_ev = key_ev && (key_i == KEY_ENTER);

  assign tick_run   = (state_q == ST_COUNTDOWN) || (state_q == ST_RACE);
  assign tick_clear = (state_d != state_q) &&
                      ((state_d == ST_COUNTDOWN) || (state_d == ST_RACE));

  cs_tick #(.CLK_TICKS(CLK_TICKS)) u_cs_tick (
    .pclk  (pclk),
    .rst   (rst),
    .clear (tick_clear),
    .run   (tick_run),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cd_d    = cd_q;
    sec_d   = sec_q;
    laps_d  = laps_q;
    lap_t_d = lap_t_q;
    best_d  = best_q;
    total_d = total_q;
    go_d    = 1'b0;
    done_d  = 1'b0;
    lap_ev  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !start_q) begin
          state_d = ST_COUNTDOWN;
          cd_d    = CD_INIT;
          sec_d   = '0;
        end
      end
      ST_COUNTDOWN: begin
        if (tick) begin
          if (sec_q == SEC_LAST) begin
            sec_d = '0;
            if (cd_q <= 2'd1) begin
              state_d = ST_RACE;
              go_d    = 1'b1;
              cd_d    = '0;
              lap_t_d = '0;
              total_d = '0;
            end else begin
              cd_d = cd_q - 2'd1;
            end
          end else begin
            sec_d = sec_q + 7'd1;
          end
        end
      end
      ST_RACE: begin
        // Lap decision uses the armed value from before this edge
        lap_ev = finish_line_hit_i && armed_q;
        if (tick) begin
          if (total_q != TOTAL_MAX_CS) total_d = total_q + 18'd1;
          if (!lap_ev && (lap_t_q < LAP_MAX_CS)) lap_t_d = lap_t_q + 16'd1;
        end
        if (lap_ev) begin
          laps_d  = laps_q + 3'd1;
          armed_d = 1'b0;
          lap_t_d = '0;
          if (lap_t_q < best_q) best_d = lap_t_q;
        end else if (checkpoint_hit_i) begin
          armed_d = 1'b1;
        end
        if (lap_ev && (laps_d == LAPS_DONE)) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else if (esc_ev) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (esc_ev || enter_ev) state_d = ST_RACE;
      end
      ST_FINISH: begin
        if (enter_ev) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && !start_i) state_d = ST_IDLE;

    // Everything but the best lap returns to its reset value in IDLE
    if (state_d == ST_IDLE) begin
      armed_d = 1'b0;
      cd_d    = '0;
      sec_d   = '0;
      laps_d  = '0;
      lap_t_d = '0;
      total_d = '0;
      go_d    = 1'b0;
      done_d  = 1'b0;
    end

    pen_d = (state_d == ST_RACE);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      key_q   <= KEY_NONE;
      armed_q <= 1'b0;
      cd_q    <= '0;
      sec_q   <= '0;
      pen_q   <= 1'b0;
      go_q    <= 1'b0;
      laps_q  <= '0;
      lap_t_q <= '0;
      best_q  <= BEST_NONE;
      total_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      key_q   <= key_i;
      armed_q <= armed_d;
      cd_q    <= cd_d;
      sec_q   <= sec_d;
      pen_q   <= pen_d;
      go_q    <= go_d;
      laps_q  <= laps_d;
      lap_t_q <= lap_t_d;
      best_q  <= best_d;
      total_q <= total_d;
      done_q  <= done_d;
    end
  end

  assign race_state_o    = state_q;
  assign countdown_val_o = cd_q;
  assign player_enable_o = pen_q;
  assign go_pulse_o      = go_q;
  assign lap_count_o     = laps_q;
  assign lap_time_cs_o   = lap_t_q;
  assign best_lap_cs_o   = best_q;
  assign total_time_cs_o = total_q;
  assign race_done_o     = done_q;

endmodule

// File: tb/tb_race_ctrl.sv
// tb/tb_race_ctrl.sv - scoreboard bench for race_ctrl against a behavioural race model
module tb_race_ctrl;
  import race_pkg::*;

  localparam int CT = 4;
  localparam int NL = 2;
  localparam int CS = 3;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  key = 6'b0;
  logic        cp = 1'b0;
  logic        fin = 1'b0;
  logic [2:0]  race_state;
  logic [1:0]  countdown_val;
  logic        player_enable;
  logic        go_pulse;
  logic [2:0]  lap_count;
  logic [15:0] lap_time_cs;
  logic [15:0] best_lap_cs;
  logic [17:0] total_time_cs;
  logic        race_done;

  always #5 pclk = ~pclk;

  race_ctrl #(.CLK_TICKS(CT), .LAPS(NL), .COUNTDOWN_S(CS)) dut (
    .pclk              (pclk),
    .rst               (rst),
    .start_i           (start),
    .key_i             (key),
    .checkpoint_hit_i  (cp),
    .finish_line_hit_i (fin),
    .race_state_o      (race_state),
    .countdown_val_o   (countdown_val),
    .player_enable_o   (player_enable),
    .go_pulse_o        (go_pulse),
    .lap_count_o       (lap_count),
    .lap_time_cs_o     (lap_time_cs),
    .best_lap_cs_o     (best_lap_cs),
    .total_time_cs_o   (total_time_cs),
    .race_done_o       (race_done)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [1:0]  cd;
    logic        pen;
    logic        go;
    logic [2:0]  laps;
    logic [15:0] lap;
    logic [15:0] best;
    logic [17:0] total;
    logic        done;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Phases: 0 idle, 1 countdown, 2 race, 3 pause, 4 finish
  int   m_st, m_cd, m_cd_ticks, m_run, m_laps, m_lap, m_best, m_total;
  bit   m_pen, m_go, m_done, m_armed, m_start_prev;
  logic [5:0] m_key_prev;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic model_step();
    int  ns;
    bit  tick, kev, lap_ev;
    snap_t s;
    if (rst) begin
      m_st = 0; m_cd = 0; m_cd_ticks = 0; m_run = 0; m_laps = 0; m_lap = 0;
      m_best = 65535; m_total = 0; m_pen = 0; m_go = 0; m_done = 0;
      m_armed = 0; m_start_prev = 0; m_key_prev = 6'b0;
    end else begin
      tick = (m_st == 1 || m_st == 2) && ((m_run % CT) == CT - 1);
      kev  = (key != 6'b0) && (m_key_prev == 6'b0);
      ns = m_st; m_go = 0; m_done = 0; lap_ev = 0;
      case (m_st)
        0: if (start && !m_start_prev) begin ns = 1; m_cd = CS; m_cd_ticks = 0; end
        1: if (tick) begin
             m_cd_ticks++;
             if (m_cd_ticks == CS * 100) begin
               ns = 2; m_go = 1; m_cd = 0; m_lap = 0; m_total = 0;
             end else begin
               m_cd = CS - m_cd_ticks / 100;
             end
           end
        2: begin
             lap_ev = fin && m_armed;
             if (tick) begin
               if (m_total < 262143) m_total++;
               if (!lap_ev && m_lap < 59999) m_lap++;
             end
             if (lap_ev) begin
               m_laps++;
               if (m_lap < m_best) m_best = m_lap;
               m_lap = 0; m_armed = 0;
             end else if (cp) begin
               m_armed = 1;
             end
             if (lap_ev && m_laps == NL) begin ns = 4; m_done = 1; end
             else if (kev && key == KEY_ESC) ns = 3;
           end
        3: if (kev && (key == KEY_ESC || key == KEY_ENTER)) ns = 2;
        4: if (kev && key == KEY_ENTER) ns = 0;
        default: ns = 0;
      endcase
      if (m_st != 0 && !start) ns = 0;
      if (ns == 0) begin
        m_cd = 0; m_armed = 0; m_laps = 0; m_lap = 0; m_total = 0; m_go = 0; m_done = 0;
      end
      m_pen = (ns == 2);
      if (!(ns == 1 || ns == 2) || ns != m_st) m_run = 0;
      else m_run++;
      m_st = ns; m_start_prev = start; m_key_prev = key;
    end
    s.st = 3'(m_st); s.cd = 2'(m_cd); s.pen = m_pen; s.go = m_go;
    s.laps = 3'(m_laps); s.lap = 16'(m_lap); s.best = 16'(m_best);
    s.total = 18'(m_total); s.done = m_done;
    exp_q.push_back(s);
  endtask

  initial forever begin
    @(posedge pclk);
    model_step();
  end

  initial forever begin
    snap_t e, a;
    @(negedge pclk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.st = race_state; a.cd = countdown_val; a.pen = player_enable; a.go = go_pulse;
      a.laps = lap_count; a.lap = lap_time_cs; a.best = best_lap_cs;
      a.total = total_time_cs; a.done = race_done;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_snapshot t=%0t: actual st=%0d cd=%0d pen=%0d go=%0d laps=%0d lap=%0d best=%0d total=%0d done=%0d required st=%0d cd=%0d pen=%0d go=%0d laps=%0d lap=%0d best=%0d total=%0d done=%0d",
                 $time, a.st, a.cd, a.pen, a.go, a.laps, a.lap, a.best, a.total, a.done,
                 e.st, e.cd, e.pen, e.go, e.laps, e.lap, e.best, e.total, e.done);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic wait_race(input string name);
    int n = 0;
    do begin
      cyc(1);
      n++;
      if (n == 1) begin
        check({name, "_cd_entry"}, race_state, 1);
        check({name, "_cd_val"}, countdown_val, CS);
      end
    end while (race_state != 3'(ST_RACE) && n < 1500);
    check({name, "_race_latency"}, n, 1201);
  endtask

  task automatic wait_model_lap(input int target, input string name);
    int n = 0;
    while (m_lap != target && n < 1000) begin
      cyc(1);
      n++;
    end
    check(name, m_lap, target);
  endtask

  logic [5:0] keys [7];
  int tot_snap, lap_snap;

  initial begin
    keys = '{KEY_NONE, KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_ENTER, KEY_ESC};
    cyc(3);
    check("reset_state", race_state, 0);
    check("reset_best", best_lap_cs, 16'hFFFF);
    rst = 1'b0;
    cyc(2);

    // Race 1: countdown, unarmed finish, two laps, pause, finish
    start = 1'b1;
    wait_race("race1");
    cyc(10);
    fin = 1'b1; cyc(1); fin = 1'b0;
    check("unarmed_finish", lap_count, 0);
    cp = 1'b1; cyc(1); cp = 1'b0;
    wait_model_lap(25, "wait_lap25");
    fin = 1'b1; cyc(1); fin = 1'b0;
    check("lap1_count", lap_count, 1);
    check("lap1_best", best_lap_cs, 25);
    check("lap1_time_reset", lap_time_cs, 0);
    key = KEY_ESC; cyc(1); key = KEY_NONE;
    check("pause_entry", race_state, 3);
    tot_snap = m_total; lap_snap = m_lap;
    cyc(100);
    check("pause_total_frozen", total_time_cs, tot_snap);
    check("pause_lap_frozen", lap_time_cs, lap_snap);
    key = KEY_ENTER; cyc(50); key = KEY_NONE;
    check("resume_race", race_state, 2);
    cp = 1'b1; cyc(1); cp = 1'b0;
    wait_model_lap(18, "wait_lap18");
    fin = 1'b1; cyc(1); fin = 1'b0;
    check("finish_state", race_state, 4);
    check("finish_done_pulse", race_done, 1);
    check("finish_best", best_lap_cs, 18);
    check("finish_laps", lap_count, 2);
    cyc(1);
    check("done_one_cycle", race_done, 0);
    tot_snap = m_total;
    cyc(30);
    check("finish_total_frozen", total_time_cs, tot_snap);
    key = KEY_ENTER; cyc(1); key = KEY_NONE;
    check("finish_to_idle", race_state, 0);
    check("idle_best_held", best_lap_cs, 18);

    // Race 2: same-cycle checkpoint+finish, then abort
    start = 1'b0; cyc(2); start = 1'b1;
    wait_race("race2");
    cp = 1'b1; fin = 1'b1; cyc(1); cp = 1'b0; fin = 1'b0;
    check("same_cycle_no_lap", lap_count, 0);
    cyc(5);
    fin = 1'b1; cyc(1); fin = 1'b0;
    check("armed_by_same_cycle", lap_count, 1);
    start = 1'b0; cyc(1);
    check("abort_idle", race_state, 0);
    check("abort_laps_cleared", lap_count, 0);

    // Race 3: reset mid-countdown
    start = 1'b1; cyc(500);
    check("mid_countdown", race_state, 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("rst_state", race_state, 0);
    check("rst_best", best_lap_cs, 16'hFFFF);
    check("rst_cd", countdown_val, 0);

    // Randomised traffic, checked cycle by cycle against the model
    for (int i = 0; i < 7000; i++) begin
      if (start) begin
        if ($urandom_range(0, 2999) == 0) start = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        start = 1'b1;
      end
      rst = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 29) == 0) key = keys[$urandom_range(0, 6)];
      cp  = ($urandom_range(0, 39) == 0);
      fin = ($urandom_range(0, 39) == 0);
      cyc(1);
    end
    rst = 1'b0; key = KEY_NONE; cp = 1'b0; fin = 1'b0; start = 1'b0;
    cyc(3);
    @(negedge pclk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
